// File: rtl/fuzzify_seq_pkg.sv
// Shared definitions for the fuzzification sequencer.
//   X_W    : crisp input width, signed Q7.0
//   MU_W   : membership degree width, Q1.15
//   MU_ONE : full membership (0x7FFF)
//   CFG_W  : config word width, {a,b,c,d}
//   fz_state_e : sequencer states FZ_IDLE/FZ_EVAL/FZ_DRAIN/FZ_DONE
//   mf_t   : one trapezoid MF, a in the top byte
package fuzzify_seq_pkg;
  localparam int X_W   = 8;
  localparam int MU_W  = 16;
  localparam int CFG_W = 32;
  localparam logic [MU_W-1:0] MU_ONE = 16'h7FFF;

  typedef enum logic [1:0] {FZ_IDLE, FZ_EVAL, FZ_DRAIN, FZ_DONE} fz_state_e;

  typedef struct packed {
    logic signed [X_W-1:0] a;
    logic signed [X_W-1:0] b;
    logic signed [X_W-1:0] c;
    logic signed [X_W-1:0] d;
  } mf_t;

  function automatic logic mf_ordered(mf_t m);
    return (m.a <= m.b) && (m.b <= m.c) && (m.c <= m.d);
  endfunction
endpackage

// File: rtl/fuzzify_seq_trap.sv
// Combinational trapezoid membership evaluator.
//   x  : crisp input, signed Q7.0
//   mf : trapezoid corners a<=b<=c<=d
//   mu : membership degree, Q1.15, saturated to MU_ONE
module fuzzify_seq_trap
  import fuzzify_seq_pkg::*;
(
  input  logic signed [X_W-1:0] x,
  input  mf_t                   mf,
  output logic [MU_W-1:0]       mu
);
  logic signed [X_W:0] xe, ae, be, ce, de;
  logic [X_W:0]        num_d, den_d;
  logic [X_W+15:0]     num, den, q;

  // one extra bit so corner differences across the full signed range cannot wrap
  assign xe = {x[X_W-1], x};
  assign ae = {mf.a[X_W-1], mf.a};
  assign be = {mf.b[X_W-1], mf.b};
  assign ce = {mf.c[X_W-1], mf.c};
  assign de = {mf.d[X_W-1], mf.d};

  always_comb begin
    num_d = '0;
    den_d = '0;
    mu    = '0;
    if (x < mf.b) begin
      num_d = xe - ae;
      den_d = be - ae;
    end else begin
      num_d = de - xe;
      den_d = de - ce;
    end
    num = {num_d, 15'd0};
    // a zero divisor only arises from degenerate slopes; treat it as 1
    den = (den_d == '0) ? {{(X_W+15){1'b0}}, 1'b1} : {15'd0, den_d};
    q   = num / den;
    if (x <= mf.a || x >= mf.d)      mu = '0;
    else if (x >= mf.b && x <= mf.c) mu = MU_ONE;
    else if (|q[X_W+15:15])          mu = MU_ONE;
    else                             mu = q[MU_W-1:0];
  end
endmodule

// File: rtl/fuzzify_seq.sv
// Fuzzification sequencer: sweeps one shared trapezoid evaluator across the
// NUM_MF stored membership functions for a latched crisp input and streams
// one mu per MF in index order.
//   clk, rst_n            : clock, async active-low reset (clears the table too)
//   start, x_in           : begin a sweep with x_in (accepted only when idle)
//   busy, done            : sweep in progress / one-cycle end-of-sweep pulse
//   mu_valid/mu_idx/mu_out: streamed membership results
//   cfg_we/cfg_addr/cfg_data, cfg_err : table write port, reject pulse
// Build option FUZZ_PIPE_EN: adds a register between the table read and the
// evaluator, delaying every mu_valid and done by one cycle.
module fuzzify_seq
  import fuzzify_seq_pkg::*;
#(
  parameter int NUM_MF = 4,
  parameter int IDX_W  = 2
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [X_W-1:0]       x_in,
  output logic                 busy,
  output logic                 done,
  output logic                 mu_valid,
  output logic [IDX_W-1:0]     mu_idx,
  output logic [MU_W-1:0]      mu_out,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic [CFG_W-1:0]     cfg_data,
  output logic                 cfg_err
);
`ifdef FUZZ_PIPE_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MF - 1);

  fz_state_e                   state, state_nx;
  logic [IDX_W-1:0]            cnt;
  logic signed [X_W-1:0]       x_lat, x_ev;
  mf_t [NUM_MF-1:0]            tbl;
  mf_t                         mf_ev, cfg_mf;
  logic [STAGES:1]             vld_pipe;
  logic [STAGES:1][IDX_W-1:0]  idx_pipe;
  logic                        issue, ev_vld, wr_ok;
  logic [MU_W-1:0]             mu_ev;

  assign issue    = (state == FZ_EVAL);
  assign busy     = (state != FZ_IDLE);
  assign done     = (state == FZ_DONE);
  assign mu_valid = vld_pipe[STAGES];
  assign mu_idx   = idx_pipe[STAGES];
  assign cfg_mf   = mf_t'(cfg_data);
  // a write racing a start loses: the sweep must see a stable table
  assign wr_ok    = (state == FZ_IDLE) && !start && (int'(cfg_addr) < NUM_MF)
                    && mf_ordered(cfg_mf);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FZ_IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      FZ_IDLE:  if (start) state_nx = FZ_EVAL;
      FZ_EVAL:  if (cnt == LAST) state_nx = FZ_DRAIN;
      FZ_DRAIN: if (mu_valid && mu_idx == LAST) state_nx = FZ_DONE;
      FZ_DONE:  state_nx = FZ_IDLE;
      default:  state_nx = FZ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      x_lat <= '0;
    end else if (state == FZ_IDLE && start) begin
      cnt   <= '0;
      x_lat <= x_in;
    end else if (issue) begin
      cnt   <= cnt + 1'b1;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tbl     <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !wr_ok;
      if (cfg_we && wr_ok) tbl[cfg_addr] <= cfg_mf;
    end

`ifdef FUZZ_PIPE_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mf_ev <= '0;
      x_ev  <= '0;
    end else if (issue) begin
      mf_ev <= tbl[cnt];
      x_ev  <= x_lat;
    end
  assign ev_vld = vld_pipe[1];
`else
  assign mf_ev  = tbl[cnt];
  assign x_ev   = x_lat;
  assign ev_vld = issue;
`endif

  fuzzify_seq_trap u_trap (
    .x  (x_ev),
    .mf (mf_ev),
    .mu (mu_ev)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
      mu_out   <= '0;
    end else begin
      vld_pipe[1] <= issue;
      idx_pipe[1] <= cnt;
      for (int i = 2; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
      if (ev_vld) mu_out <= mu_ev;
    end
endmodule

// File: tb/tb_fuzzify_seq.sv
// Bench for fuzzify_seq: directed and random sweeps checked against an
// arithmetic trapezoid model and a per-MF table image kept in the bench.
module tb_fuzzify_seq;
  localparam int NUM_MF = 4;
  localparam int IDX_W  = 2;
`ifdef FUZZ_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, start, cfg_we;
  logic              busy, done, mu_valid, cfg_err;
  logic [7:0]        x_in;
  logic [IDX_W-1:0]  mu_idx, cfg_addr;
  logic [15:0]       mu_out;
  logic [31:0]       cfg_data;

  int errors = 0;
  int checks = 0;
  int mdl [NUM_MF][4];

  fuzzify_seq #(.NUM_MF(NUM_MF), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .busy(busy), .done(done), .mu_valid(mu_valid), .mu_idx(mu_idx),
    .mu_out(mu_out), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_mu(input int x, input int a, input int b, input int c, input int d);
    int q, den;
    if (x <= a || x >= d) return 0;
    if (x >= b && x <= c) return 32767;
    den = (x < b) ? (b - a) : (d - c);
    if (den == 0) den = 1;
    q = (x < b) ? ((x - a) * 32768) / den : ((d - x) * 32768) / den;
    return (q > 32767) ? 32767 : q;
  endfunction

  task automatic cfg(input int addr, input int a, input int b, input int c, input int d);
    bit exp_err;
    exp_err  = !(a <= b && b <= c && c <= d);
    cfg_we   = 1'b1;
    cfg_addr = addr[IDX_W-1:0];
    cfg_data = {8'(a), 8'(b), 8'(c), 8'(d)};
    tick();
    cfg_we = 1'b0;
    check($sformatf("cfg_err addr%0d (%0d,%0d,%0d,%0d)", addr, a, b, c, d), 32'(cfg_err), 32'(exp_err));
    if (!exp_err) mdl[addr] = '{a, b, c, d};
  endtask

  // mode 0: plain; 1: cfg write in the start cycle; 2: cfg write while busy;
  // 3: x_in changed in cycle 1 and start re-pulsed in cycle 2
  task automatic sweep(input logic signed [7:0] x, input int mode, input string tag);
    int got, cyc, ndone, r;
    got = 0; cyc = 1; ndone = 0;
    x_in  = x;
    start = 1'b1;
    if (mode == 1) begin cfg_we = 1'b1; cfg_addr = 0; cfg_data = 32'h01020304; end
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    if (mode == 3) x_in = x + 8'sd7;
    if (mode == 1) check({tag, " cfg_err with start"}, 32'(cfg_err), 1);
    check({tag, " busy"}, 32'(busy), 1);
    if (mode == 2) begin cfg_we = 1'b1; cfg_addr = 1; cfg_data = 32'h01020304; end
    while (ndone == 0 && cyc < 30) begin
      if (mode == 2 && cyc == 2) check({tag, " cfg_err busy"}, 32'(cfg_err), 1);
      start = (mode == 3 && cyc == 2);
      if (mu_valid) begin
        check({tag, " extra mu"}, 32'(got < NUM_MF), 1);
        if (got < NUM_MF) begin
          r = ref_mu(int'(x), mdl[got][0], mdl[got][1], mdl[got][2], mdl[got][3]);
          check($sformatf("%s idx%0d", tag, got), 32'(mu_idx), 32'(got));
          check($sformatf("%s mu%0d x=%0d", tag, got, x), 32'(mu_out), 32'(r));
          check($sformatf("%s mu%0d cycle", tag, got), 32'(cyc), 32'(got + 2 + PIPE));
        end
        got++;
      end
      if (done) begin
        ndone++;
        check({tag, " done cycle"}, 32'(cyc), 32'(NUM_MF + 2 + PIPE));
      end
      tick();
      cyc++;
      cfg_we = 1'b0;
    end
    start = 1'b0;
    check({tag, " done seen"}, 32'(ndone), 1);
    check({tag, " mu count"}, 32'(got), 32'(NUM_MF));
    check({tag, " idle after"}, 32'(busy), 0);
  endtask

  initial begin
    int v[4];
    int t, xi;
    rst_n = 1'b0; start = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; x_in = '0;
    foreach (mdl[i, j]) mdl[i][j] = 0;
    #12;
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst mu_valid", 32'(mu_valid), 0);
    check("rst mu_idx", 32'(mu_idx), 0);
    check("rst mu_out", 32'(mu_out), 0);
    check("rst cfg_err", 32'(cfg_err), 0);
    rst_n = 1'b1;
    tick();

    sweep(0, 0, "zero_tbl");

    cfg(0, -20, -10, 10, 20);
    sweep(0, 0, "mf0 x0");
    sweep(-15, 0, "mf0 x-15");
    sweep(-20, 0, "mf0 x-20");
    sweep(20, 0, "mf0 x20");

    cfg(1, 0, 20, 20, 40);
    sweep(20, 0, "tri x20");
    sweep(30, 0, "tri x30");
    sweep(10, 0, "tri x10");

    cfg(0, 10, 5, 20, 30);
    sweep(-15, 0, "bad cfg kept");
    sweep(0, 1, "cfg+start");
    sweep(-15, 2, "cfg busy");
    sweep(-15, 3, "restart");
    sweep(30, 0, "back2back");

    for (int r = 0; r < 8; r++) begin
      for (int m = 0; m < NUM_MF; m++) begin
        foreach (v[i]) v[i] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3 - i; j++)
            if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        if (r % 3 == 0 && m == 2) cfg(m, v[3], v[2], v[1], v[0]);
        else                      cfg(m, v[0], v[1], v[2], v[3]);
      end
      xi = mdl[r % NUM_MF][r % 4] + int'($urandom_range(0, 2)) - 1;
      if (xi > 127) xi = 127;
      if (xi < -128) xi = -128;
      sweep(8'(xi), 0, $sformatf("rand%0d edge", r));
      sweep(8'($urandom_range(0, 255)), 0, $sformatf("rand%0d", r));
    end

    // asynchronous reset in cycle 3 of a sweep
    cfg(2, -50, -40, 40, 50);
    x_in = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 0);
    check("midrst done", 32'(done), 0);
    check("midrst mu_valid", 32'(mu_valid), 0);
    check("midrst mu_idx", 32'(mu_idx), 0);
    check("midrst mu_out", 32'(mu_out), 0);
    check("midrst cfg_err", 32'(cfg_err), 0);
    tick();
    rst_n = 1'b1;
    foreach (mdl[i, j]) mdl[i][j] = 0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("postrst done c%0d", i), 32'(done), 0);
      check($sformatf("postrst valid c%0d", i), 32'(mu_valid), 0);
      tick();
    end
    sweep(8'sd5, 0, "tbl cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
